// File: rtl/irb_tile_sequencer_if.sv
// Tile-sequencer bus: layer descriptor in, tile descriptors out.
// master = layer controller / loader side, slave = the sequencer.
interface irb_tile_sequencer_if #(
  parameter int unsigned DIM_W = 8,
  parameter int unsigned CH_W  = 11,
  parameter int unsigned ADR_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIM_W-1:0] cfg_nox;
  logic [DIM_W-1:0] cfg_noy;
  logic [CH_W-1:0]  cfg_nif;
  logic [1:0]       cfg_stride;
  logic             abort;
  logic             tile_valid;
  logic             tile_ready;
  logic [DIM_W-1:0] tile_ox0;
  logic [DIM_W-1:0] tile_oy0;
  logic [DIM_W-1:0] tile_tox;
  logic [DIM_W-1:0] tile_toy;
  logic [DIM_W-1:0] tile_ix0;
  logic [DIM_W-1:0] tile_iy0;
  logic [DIM_W-1:0] tile_tix;
  logic [DIM_W-1:0] tile_tiy;
  logic [CH_W-1:0]  tile_grp;
  logic [ADR_W-1:0] tile_fmo_off;
  logic             tile_last;
  logic             done;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_nox, cfg_noy, cfg_nif, cfg_stride, abort, tile_ready,
    input  cfg_ready, tile_valid, tile_ox0, tile_oy0, tile_tox, tile_toy,
           tile_ix0, tile_iy0, tile_tix, tile_tiy, tile_grp, tile_fmo_off,
           tile_last, done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_nox, cfg_noy, cfg_nif, cfg_stride, abort, tile_ready,
    output cfg_ready, tile_valid, tile_ox0, tile_oy0, tile_tox, tile_toy,
           tile_ix0, tile_iy0, tile_tix, tile_tiy, tile_grp, tile_fmo_off,
           tile_last, done, cfg_err
  );
endinterface

// File: rtl/irb_tile_sequencer.sv
// Tile scheduler for the inverted-residual-block datapath: walks a layer in
// (channel group, x tile, y tile) order and emits one registered descriptor
// per step, with edge clipping and stride-1/2 input windows.
module irb_tile_sequencer #(
  parameter int unsigned NKX   = 3,
  parameter int unsigned NKY   = 3,
  parameter int unsigned TOX   = 7,
  parameter int unsigned TOY   = 7,
  parameter int unsigned NPAR  = 2,
  parameter int unsigned DIM_W = 8,
  parameter int unsigned CH_W  = 11,
  parameter int unsigned ADR_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  irb_tile_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  localparam logic [DIM_W-1:0] TOX_C  = DIM_W'(TOX);
  localparam logic [DIM_W-1:0] TOY_C  = DIM_W'(TOY);
  localparam logic [DIM_W-1:0] ONE_D  = DIM_W'(1);
  localparam logic [DIM_W:0]   NKX_C  = (DIM_W+1)'(NKX);
  localparam logic [DIM_W:0]   NKY_C  = (DIM_W+1)'(NKY);
  localparam logic [CH_W-1:0]  NPAR_C = CH_W'(NPAR);
  localparam logic [CH_W-1:0]  ONE_C  = CH_W'(1);

  logic [1:0]       state_q;
  logic [DIM_W-1:0] nox_q, noy_q;
  logic [CH_W-1:0]  nif_q, ngrp_q;
  logic [1:0]       stride_q;

  logic             valid_q, last_q, done_q, err_q;
  logic [DIM_W-1:0] ox0_q, oy0_q, tox_q, toy_q, ix0_q, iy0_q, tix_q, tiy_q;
  logic [CH_W-1:0]  grp_q;
  logic [ADR_W-1:0] fmo_q;

  logic [CH_W-1:0]  ngrp_calc, ngrp_use;
  logic [DIM_W-1:0] px, py;
  logic [CH_W-1:0]  pg;
  logic [DIM_W-1:0] rem_x, rem_y, f_tox, f_toy, tx_m1, ty_m1, f_ix0, f_iy0, f_tix, f_tiy;
  logic [DIM_W:0]   tix_w, tiy_w;
  logic [ADR_W-1:0] f_fmo;
  logic             f_last;
  logic             cfg_ok;

  assign bus.cfg_ready    = (state_q == IDLE);
  assign bus.tile_valid   = valid_q;
  assign bus.tile_ox0     = ox0_q;
  assign bus.tile_oy0     = oy0_q;
  assign bus.tile_tox     = tox_q;
  assign bus.tile_toy     = toy_q;
  assign bus.tile_ix0     = ix0_q;
  assign bus.tile_iy0     = iy0_q;
  assign bus.tile_tix     = tix_q;
  assign bus.tile_tiy     = tiy_q;
  assign bus.tile_grp     = grp_q;
  assign bus.tile_fmo_off = fmo_q;
  assign bus.tile_last    = last_q;
  assign bus.done         = done_q;
  assign bus.cfg_err      = err_q;

  assign cfg_ok = (bus.cfg_nox != '0) && (bus.cfg_noy != '0) && (bus.cfg_nif != '0) &&
                  ((bus.cfg_stride == 2'd1) || (bus.cfg_stride == 2'd2));

  // Group count; CALC uses the freshly computed value before it is registered.
  always_comb begin
    ngrp_calc = nif_q / NPAR_C + (((nif_q % NPAR_C) != '0) ? ONE_C : '0);
    ngrp_use  = (state_q == CALC) ? ngrp_calc : ngrp_q;
  end

  // Position of the next descriptor, derived from the one currently presented.
  always_comb begin
    px = '0;
    py = '0;
    pg = '0;
    if (state_q != CALC) begin
      if (grp_q != ngrp_use - ONE_C) begin
        px = ox0_q;
        py = oy0_q;
        pg = grp_q + ONE_C;
      end else if (ox0_q + tox_q != nox_q) begin
        px = ox0_q + tox_q;
        py = oy0_q;
      end else begin
        py = oy0_q + toy_q;
      end
    end
  end

  // Descriptor fields for position (px, py, pg).
  always_comb begin
    rem_x  = nox_q - px;
    rem_y  = noy_q - py;
    f_tox  = (rem_x > TOX_C) ? TOX_C : rem_x;
    f_toy  = (rem_y > TOY_C) ? TOY_C : rem_y;
    tx_m1  = f_tox - ONE_D;
    ty_m1  = f_toy - ONE_D;
    tix_w  = (stride_q == 2'd2) ? ({tx_m1, 1'b0} + NKX_C) : ({1'b0, tx_m1} + NKX_C);
    tiy_w  = (stride_q == 2'd2) ? ({ty_m1, 1'b0} + NKY_C) : ({1'b0, ty_m1} + NKY_C);
    f_tix  = tix_w[DIM_W] ? '1 : tix_w[DIM_W-1:0];
    f_tiy  = tiy_w[DIM_W] ? '1 : tiy_w[DIM_W-1:0];
    f_ix0  = (stride_q == 2'd2) ? {px[DIM_W-2:0], 1'b0} : px;
    f_iy0  = (stride_q == 2'd2) ? {py[DIM_W-2:0], 1'b0} : py;
    f_fmo  = ADR_W'(py) * ADR_W'(nox_q) + ADR_W'(px);
    f_last = (pg == ngrp_use - ONE_C) &&
             (({1'b0, px} + {1'b0, f_tox}) == {1'b0, nox_q}) &&
             (({1'b0, py} + {1'b0, f_toy}) == {1'b0, noy_q});
  end

  // FSM and registered descriptor outputs; abort takes priority over handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      nox_q    <= '0;
      noy_q    <= '0;
      nif_q    <= '0;
      stride_q <= '0;
      ngrp_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ox0_q    <= '0;
      oy0_q    <= '0;
      tox_q    <= '0;
      toy_q    <= '0;
      ix0_q    <= '0;
      iy0_q    <= '0;
      tix_q    <= '0;
      tiy_q    <= '0;
      grp_q    <= '0;
      fmo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cfg_valid) begin
            nox_q    <= bus.cfg_nox;
            noy_q    <= bus.cfg_noy;
            nif_q    <= bus.cfg_nif;
            stride_q <= bus.cfg_stride;
            if (cfg_ok) state_q <= CALC;
            else        err_q   <= 1'b1;
          end
        end
        CALC, EMIT: begin
          if (bus.abort) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= IDLE;
          end else if (state_q == EMIT && valid_q && bus.tile_ready && last_q) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (state_q == CALC || (valid_q && bus.tile_ready)) begin
            if (state_q == CALC) ngrp_q <= ngrp_calc;
            valid_q <= 1'b1;
            last_q  <= f_last;
            ox0_q   <= px;
            oy0_q   <= py;
            grp_q   <= pg;
            tox_q   <= f_tox;
            toy_q   <= f_toy;
            ix0_q   <= f_ix0;
            iy0_q   <= f_iy0;
            tix_q   <= f_tix;
            tiy_q   <= f_tiy;
            fmo_q   <= f_fmo;
            state_q <= EMIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irb_tile_sequencer.sv
// Scoreboard bench for irb_tile_sequencer: expected descriptors are queued
// from a loop model when a layer is configured and popped on each handshake.
module tb_irb_tile_sequencer;

  typedef struct {
    int ox0, oy0, tox, toy, ix0, iy0, tix, tiy, grp, fmo, last;
  } tile_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  tile_t exp_q[$];

  always #5 clk = ~clk;

  irb_tile_sequencer_if #(.DIM_W(8), .CH_W(11), .ADR_W(16)) bus ();

  irb_tile_sequencer #(
    .NKX(3), .NKY(3), .TOX(7), .TOY(7), .NPAR(2), .DIM_W(8), .CH_W(11), .ADR_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic tile_t cur_tile();
    tile_t t;
    t.ox0 = int'(bus.tile_ox0);  t.oy0 = int'(bus.tile_oy0);
    t.tox = int'(bus.tile_tox);  t.toy = int'(bus.tile_toy);
    t.ix0 = int'(bus.tile_ix0);  t.iy0 = int'(bus.tile_iy0);
    t.tix = int'(bus.tile_tix);  t.tiy = int'(bus.tile_tiy);
    t.grp = int'(bus.tile_grp);  t.fmo = int'(bus.tile_fmo_off);
    t.last = int'(bus.tile_last);
    return t;
  endfunction

  task automatic cmp_tile(input string p, input tile_t g, input tile_t e);
    chk({p, "_ox0"}, g.ox0, e.ox0);  chk({p, "_oy0"}, g.oy0, e.oy0);
    chk({p, "_tox"}, g.tox, e.tox);  chk({p, "_toy"}, g.toy, e.toy);
    chk({p, "_ix0"}, g.ix0, e.ix0);  chk({p, "_iy0"}, g.iy0, e.iy0);
    chk({p, "_tix"}, g.tix, e.tix);  chk({p, "_tiy"}, g.tiy, e.tiy);
    chk({p, "_grp"}, g.grp, e.grp);  chk({p, "_fmo"}, g.fmo, e.fmo);
    chk({p, "_last"}, g.last, e.last);
  endtask

  // Reference walk of the layer: groups innermost, then x, then y.
  task automatic build_expected(input int nox, input int noy, input int nif, input int s);
    int ngrp;
    tile_t t;
    ngrp = (nif + 1) / 2;
    for (int oy = 0; oy < noy; oy += 7)
      for (int ox = 0; ox < nox; ox += 7)
        for (int g = 0; g < ngrp; g++) begin
          t.ox0 = ox;  t.oy0 = oy;
          t.tox = (nox - ox < 7) ? nox - ox : 7;
          t.toy = (noy - oy < 7) ? noy - oy : 7;
          t.ix0 = ox * s;  t.iy0 = oy * s;
          t.tix = (t.tox - 1) * s + 3;
          t.tiy = (t.toy - 1) * s + 3;
          t.grp = g;
          t.fmo = oy * nox + ox;
          t.last = ((oy + 7 >= noy) && (ox + 7 >= nox) && (g == ngrp - 1)) ? 1 : 0;
          exp_q.push_back(t);
        end
  endtask

  // Presents one layer descriptor; returns at the negedge of the cycle after acceptance.
  task automatic start_cfg(input int nox, input int noy, input int nif, input int s);
    @(negedge clk);
    chk("cfg_ready_idle", int'(bus.cfg_ready), 1);
    bus.cfg_nox = 8'(nox);
    bus.cfg_noy = 8'(noy);
    bus.cfg_nif = 11'(nif);
    bus.cfg_stride = 2'(s);
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic run_layer(input int nox, input int noy, input int nif, input int s, input int mode);
    int cyc;
    bit finished, held;
    tile_t snap, g, e;
    build_expected(nox, noy, nif, s);
    start_cfg(nox, noy, nif, s);
    chk("calc_no_valid", int'(bus.tile_valid), 0);
    cyc = 0;
    finished = 0;
    held = 0;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) bus.tile_ready = (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
      else           bus.tile_ready = 1'b1;
      if (cyc == 1) chk("first_valid", int'(bus.tile_valid), 1);
      if (bus.tile_valid) begin
        g = cur_tile();
        if (held) cmp_tile("hold", g, snap);
        if (bus.tile_ready) begin
          held = 0;
          if (exp_q.size() == 0) chk("extra_tile", 1, 0);
          else begin
            e = exp_q.pop_front();
            cmp_tile("tile", g, e);
          end
          if (bus.tile_last) begin
            @(negedge clk);
            bus.tile_ready = 1'b0;
            chk("done_pulse", int'(bus.done), 1);
            chk("valid_after_last", int'(bus.tile_valid), 0);
            chk("cfg_ready_at_done", int'(bus.cfg_ready), 1);
            @(negedge clk);
            chk("done_one_cycle", int'(bus.done), 0);
            finished = 1;
          end
        end else begin
          held = 1;
          snap = g;
        end
      end
    end
    if (!finished) chk("layer_timeout", 0, 1);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic bad_cfg(input int nif, input int s);
    int seen;
    start_cfg(7, 7, nif, s);
    chk("cfg_err_pulse", int'(bus.cfg_err), 1);
    chk("cfg_ready_err", int'(bus.cfg_ready), 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.tile_valid || bus.cfg_err || !bus.cfg_ready) seen++;
    end
    chk("err_quiet", seen, 0);
  endtask

  initial begin
    int d0;
    tile_t z;
    bus.cfg_valid = 1'b0;
    bus.cfg_nox = '0;
    bus.cfg_noy = '0;
    bus.cfg_nif = '0;
    bus.cfg_stride = '0;
    bus.abort = 1'b0;
    bus.tile_ready = 1'b0;
    repeat (3) @(negedge clk);
    z = '{default: 0};
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("rst_valid", int'(bus.tile_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.cfg_err), 0);
    cmp_tile("rst", cur_tile(), z);
    rst_n = 1'b1;

    run_layer(7, 7, 4, 1, 0);
    run_layer(10, 10, 2, 1, 0);
    run_layer(4, 4, 2, 2, 0);
    run_layer(10, 10, 2, 1, 1);
    run_layer(9, 5, 5, 2, 1);
    run_layer(1, 1, 1, 1, 0);

    bad_cfg(4, 3);
    bad_cfg(0, 1);

    // abort while the second descriptor is presented, ready high in the same cycle
    d0 = done_cnt;
    start_cfg(10, 10, 2, 1);
    bus.tile_ready = 1'b1;
    @(negedge clk);
    chk("ab_first_valid", int'(bus.tile_valid), 1);
    @(negedge clk);
    chk("ab_second_ox0", int'(bus.tile_ox0), 7);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.tile_ready = 1'b0;
    chk("ab_valid_low", int'(bus.tile_valid), 0);
    chk("ab_cfg_ready", int'(bus.cfg_ready), 1);
    @(negedge clk);
    chk("ab_no_done", done_cnt - d0, 0);
    run_layer(7, 7, 4, 1, 0);

    // reset while the third descriptor is presented
    d0 = done_cnt;
    start_cfg(10, 10, 2, 1);
    bus.tile_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rs_third_oy0", int'(bus.tile_oy0), 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.tile_ready = 1'b0;
    chk("rs_valid_low", int'(bus.tile_valid), 0);
    chk("rs_oy0_clr", int'(bus.tile_oy0), 0);
    chk("rs_cfg_ready", int'(bus.cfg_ready), 1);
    @(negedge clk);
    chk("rs_no_done", done_cnt - d0, 0);
    run_layer(4, 4, 2, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
